// File: rtl/pwm_breathe_array.sv
// Multi-channel LED PWM breathing engine: one shared period counter feeding
// per-channel comparators whose duty ramps between programmable bounds.
module pwm_breathe_array #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned PWM_FREQ = 1250,
  parameter int unsigned PERIOD   = CLK_FREQ / PWM_FREQ,
  parameter int unsigned STAGGER  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] en,
  input  logic [WIDTH-1:0]    duty_min,
  input  logic [WIDTH-1:0]    duty_max,
  input  logic [WIDTH-1:0]    step,
  input  logic [WIDTH-1:0]    static_duty,
  output logic [CHANNELS-1:0] leds,
  output logic                period_tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty      [CHANNELS];
  logic [WIDTH-1:0] active    [CHANNELS];
  dir_t             dir       [CHANNELS];
  logic [WIDTH-1:0] next_duty [CHANNELS];
  dir_t             next_dir  [CHANNELS];
  mode_t            mode_q;
  mode_t            mode_in;
  logic             update;

  assign mode_in = mode_t'(mode);
  assign update  = (cnt == LAST);

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      logic [WIDTH+31:0] entry;
      logic [WIDTH:0]    up_sum;
      logic [WIDTH:0]    dn_lim;
      entry        = {32'd0, duty_min} + (WIDTH+32)'(i * STAGGER);
      up_sum       = {1'b0, duty[i]} + {1'b0, step};
      dn_lim       = {1'b0, duty_min} + {1'b0, step};
      next_duty[i] = duty[i];
      next_dir[i]  = dir[i];
      case (mode_in)
        MODE_STATIC: next_duty[i] = static_duty;
        MODE_BREATHE: begin
          // Inverted/empty bounds take precedence, including on entry.
          if (duty_min >= duty_max) begin
            next_duty[i] = duty_min;
          end else if (mode_q != MODE_BREATHE) begin
            next_duty[i] = (entry >= {32'd0, duty_max}) ? duty_max : entry[WIDTH-1:0];
            next_dir[i]  = DIR_UP;
          end else if (dir[i] == DIR_UP) begin
            if (up_sum >= {1'b0, duty_max}) begin
              next_duty[i] = duty_max;
              next_dir[i]  = DIR_DOWN;
            end else begin
              next_duty[i] = up_sum[WIDTH-1:0];
            end
          end else begin
            if ({1'b0, duty[i]} <= dn_lim) begin
              next_duty[i] = duty_min;
              next_dir[i]  = DIR_UP;
            end else begin
              next_duty[i] = duty[i] - step;
            end
          end
        end
        default: next_duty[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mode_q      <= MODE_OFF;
      leds        <= '0;
      period_tick <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty[i]   <= '0;
        active[i] <= '0;
        dir[i]    <= DIR_UP;
      end
    end else begin
      cnt         <= update ? '0 : cnt + WIDTH'(1);
      period_tick <= update;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        leds[i] <= en[i] & (cnt < active[i]);
      end
      if (update) begin
        mode_q <= mode_in;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          duty[i]   <= next_duty[i];
          active[i] <= next_duty[i];
          dir[i]    <= next_dir[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe_array.sv
// Directed bench for pwm_breathe_array with a 10-clock period and 4 channels.
module tb_pwm_breathe_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [3:0] en;
  logic [7:0] duty_min;
  logic [7:0] duty_max;
  logic [7:0] step;
  logic [7:0] static_duty;
  logic [3:0] leds;
  logic       period_tick;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [9:0]  wv [4];
  int unsigned ramp_v [6] = '{2, 4, 6, 8, 6, 4};

  pwm_breathe_array #(
    .CHANNELS(4),
    .WIDTH(8),
    .CLK_FREQ(10),
    .PWM_FREQ(1),
    .PERIOD(10),
    .STAGGER(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .en(en),
    .duty_min(duty_min),
    .duty_max(duty_max),
    .step(step),
    .static_duty(static_duty),
    .leds(leds),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  // Expected per-period LED waveform for a given duty: bit j is the slot for cnt==j.
  function automatic logic [9:0] mask(input int unsigned d);
    if (d >= 10) return 10'h3FF;
    return 10'((1 << d) - 1);
  endfunction

  // Breathe model for min=2 max=8 step=2, STAGGER=2; k counts periods since entry.
  function automatic int unsigned exp_breathe(input int unsigned c, input int unsigned k);
    if (c == 3 && k == 0) return 8;
    return ramp_v[(c == 3 ? k + 2 : k + c) % 6];
  endfunction

  task automatic wait_tick();
    int unsigned cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (period_tick === 1'b1) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_tick: got no period_tick within 30 clks, want one within 10");
  endtask

  // Called on the negedge where period_tick is high; captures one full period
  // and leaves on the next such negedge. Optionally changes static_duty mid-period.
  task automatic measure(input int unsigned chg_j, input logic [7:0] chg_val);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) wv[c][j] = leds[c];
      n_cmp++;
      if (period_tick !== (j == 9)) begin
        n_err++;
        $display("FAIL tick_slot%0d: got %b want %b", j, period_tick, (j == 9));
      end
      if (j == chg_j) static_duty = chg_val;
    end
  endtask

  task automatic test_reset();
    int unsigned cyc;
    logic        lit;
    rst_n = 1'b0; mode = 2'd1; static_duty = 8'd5; en = 4'hF;
    duty_min = 8'd2; duty_max = 8'd8; step = 8'd2;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (leds !== 4'h0 || period_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got leds=%h tick=%b want 0/0", leds, period_tick);
    end
    rst_n = 1'b1;
    wait_tick();
    measure(99, 8'd0);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (wv[c] !== mask(5)) begin
        n_err++;
        $display("FAIL pre_reset_static ch%0d: got %b want %b", c, wv[c], mask(5));
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (leds !== 4'hF) begin
      n_err++;
      $display("FAIL mid_period_leds: got %h want f", leds);
    end
    #2 rst_n = 1'b0; mode = 2'd2;
    #1;
    n_cmp++;
    if (leds !== 4'h0 || period_tick !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got leds=%h tick=%b want 0/0", leds, period_tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    lit = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (leds !== 4'h0) lit = 1'b1;
    end while (period_tick !== 1'b1 && cyc < 30);
    n_cmp++;
    if (cyc != 10) begin
      n_err++;
      $display("FAIL first_tick: got %0d clks want 10", cyc);
    end
    n_cmp++;
    if (lit !== 1'b0) begin
      n_err++;
      $display("FAIL first_period_dark: got leds lit=1 want 0");
    end
  endtask

  task automatic test_static();
    int unsigned vals [3] = '{3, 0, 12};
    mode = 2'd1;
    for (int v = 0; v < 3; v++) begin
      static_duty = 8'(vals[v]);
      measure(99, 8'd0);
      measure(99, 8'd0);
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (wv[c] !== mask(vals[v])) begin
          n_err++;
          $display("FAIL static_%0d ch%0d: got %b want %b", vals[v], c, wv[c], mask(vals[v]));
        end
      end
    end
  endtask

  task automatic test_midperiod_change();
    static_duty = 8'd3;
    measure(99, 8'd0);
    measure(3, 8'd7);
    n_cmp++;
    if (wv[0] !== mask(3)) begin
      n_err++;
      $display("FAIL change_current ch0: got %b want %b", wv[0], mask(3));
    end
    measure(99, 8'd0);
    n_cmp++;
    if (wv[0] !== mask(7)) begin
      n_err++;
      $display("FAIL change_next ch0: got %b want %b", wv[0], mask(7));
    end
  endtask

  task automatic test_breathe();
    mode = 2'd2; duty_min = 8'd2; duty_max = 8'd8; step = 8'd2; en = 4'hF;
    measure(99, 8'd0);
    for (int unsigned k = 0; k < 8; k++) begin
      measure(99, 8'd0);
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (wv[c] !== mask(exp_breathe(c, k))) begin
          n_err++;
          $display("FAIL breathe_k%0d ch%0d: got %b want %b", k, c, wv[c], mask(exp_breathe(c, k)));
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [9:0] want;
    for (int unsigned k = 8; k < 12; k++) begin
      en = (k < 10) ? 4'b0101 : 4'hF;
      measure(99, 8'd0);
      for (int c = 0; c < 4; c++) begin
        want = en[c] ? mask(exp_breathe(c, k)) : 10'h000;
        n_cmp++;
        if (wv[c] !== want) begin
          n_err++;
          $display("FAIL enable_k%0d ch%0d: got %b want %b", k, c, wv[c], want);
        end
      end
    end
  endtask

  task automatic test_hold();
    duty_min = 8'd8; duty_max = 8'd2;
    measure(99, 8'd0);
    for (int p = 0; p < 4; p++) begin
      if (p == 2) begin
        duty_min = 8'd2; duty_max = 8'd9; step = 8'd0;
        measure(99, 8'd0);
      end
      measure(99, 8'd0);
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (wv[c] !== mask(8)) begin
          n_err++;
          $display("FAIL hold_p%0d ch%0d: got %b want %b", p, c, wv[c], mask(8));
        end
      end
    end
  endtask

  task automatic test_reserved_off();
    mode = 2'd3; static_duty = 8'd5;
    measure(99, 8'd0);
    measure(99, 8'd0);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (wv[c] !== 10'h000) begin
        n_err++;
        $display("FAIL mode3_off ch%0d: got %b want %b", c, wv[c], 10'h000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_midperiod_change();
    test_breathe();
    test_enable();
    test_hold();
    test_reserved_off();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
